data_memory_responder: RTL and testbench

- Responder end of the MEM-stage control bus that the EX/MEM register drives: MEM_ENABLE, MEM_READWRITE, MEM_SIZE and MEM_SIGNE.
- Byte-addressed, big-endian data memory with a wait-state state machine.
- Performs byte, halfword and word loads and stores, including load sign or zero extension.
- Raises Stall while an access is outstanding so the pipeline holds its register enables low.

---
 rtl/data_memory_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_data_memory_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage.
// Byte-addressed, big-endian memory with a programmable wait-state FSM.
// Supports byte, halfword and word loads/stores with sign or zero extension,
// and flags misaligned accesses. Stall holds the pipeline while an access is
// outstanding. Done pulses for one cycle when the access completes.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_ENABLE,
  input  logic        MEM_READWRITE,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_SIGNE,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    rw_q, rw_d;
  logic [1:0]              size_q, size_d;
  logic                    signe_q, signe_d;
  logic [31:0]             dout_q, dout_d;
  logic                    err_q, err_d;

  logic [7:0]              mem [DEPTH];

  // Request seen by the commit logic: live inputs while in IDLE (zero-wait
  // commit happens on the capture edge), the captured copy otherwise.
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [31:0]             req_wdata;
  logic                    req_rw;
  logic [1:0]              req_size;
  logic                    req_signe;

  logic                    commit;
  logic                    misaligned;
  logic [ADDR_WIDTH-1:0]   lane_addr [4];
  logic [7:0]              rd_byte   [4];
  logic [7:0]              wr_byte   [4];
  logic [3:0]              wr_en;
  logic [31:0]             load_val;

  // Address bits above ADDR_WIDTH are deliberately ignored so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[31:ADDR_WIDTH];

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      signe_q <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      signe_q <= signe_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and wait-state counter; decides the commit edge.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_ENABLE) begin
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs: Stall drops as soon as reset is asserted.
  always_comb begin
    Stall = 1'b0;
    Done  = 1'b0;
    case (state_q)
      IDLE:    Stall = Reset & MEM_ENABLE;
      WAIT:    Stall = Reset;
      RESP:    Done  = 1'b1;
      default: ;
    endcase
  end

  // Request capture in IDLE and selection of the request used at commit.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    size_d  = size_q;
    signe_d = signe_q;
    if (state_q == IDLE && MEM_ENABLE) begin
      addr_d  = Address[ADDR_WIDTH-1:0];
      wdata_d = DataIn;
      rw_d    = MEM_READWRITE;
      size_d  = MEM_SIZE;
      signe_d = MEM_SIGNE;
    end
    if (state_q == IDLE) begin
      req_addr  = Address[ADDR_WIDTH-1:0];
      req_wdata = DataIn;
      req_rw    = MEM_READWRITE;
      req_size  = MEM_SIZE;
      req_signe = MEM_SIGNE;
    end else begin
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_rw    = rw_q;
      req_size  = size_q;
      req_signe = signe_q;
    end
  end

  // Byte lanes, alignment check, big-endian load assembly and store split.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = req_addr + ADDR_WIDTH'(i);
      rd_byte[i]   = mem[lane_addr[i]];
      wr_byte[i]   = 8'h00;
    end
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 (req_size[1] && (req_addr[1:0] != 2'b00));

    case (req_size)
      2'b00:   load_val = {{24{req_signe & rd_byte[0][7]}}, rd_byte[0]};
      2'b01:   load_val = {{16{req_signe & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
      default: load_val = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
    endcase

    wr_en = 4'b0000;
    case (req_size)
      2'b00: begin
        wr_byte[0] = req_wdata[7:0];
        wr_en      = 4'b0001;
      end
      2'b01: begin
        wr_byte[0] = req_wdata[15:8];
        wr_byte[1] = req_wdata[7:0];
        wr_en      = 4'b0011;
      end
      default: begin
        wr_byte[0] = req_wdata[31:24];
        wr_byte[1] = req_wdata[23:16];
        wr_byte[2] = req_wdata[15:8];
        wr_byte[3] = req_wdata[7:0];
        wr_en      = 4'b1111;
      end
    endcase
    if (!(commit && req_rw && !misaligned)) wr_en = 4'b0000;
  end

  // Load result and error flag, updated only when an access commits.
  always_comb begin
    dout_d = dout_q;
    err_d  = err_q;
    if (commit) begin
      if (misaligned) begin
        dout_d = '0;
        err_d  = 1'b1;
      end else begin
        err_d = 1'b0;
        if (!req_rw) dout_d = load_val;
      end
    end
  end

  // Memory array write port; gated by Reset so nothing is written while held.
  always_ff @(posedge Clk) begin
    // NOTE: the storage array has no reset; its contents survive Reset and
    // clearing it would force a flop-based implementation.
    for (int i = 0; i < 4; i++) begin
      if (Reset && wr_en[i]) mem[lane_addr[i]] <= wr_byte[i];
    end
  end

  assign DataOut = dout_q;
  assign Error   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder.
// Three instances cover WAIT_CYCLES = 1, 3 and 0. A byte-array reference
// model predicts each response; predictions go into a per-instance queue and
// a monitor compares them whenever Done is seen.
module tb_data_memory_responder;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  localparam int NDUT = 3;
  int wc [NDUT] = '{1, 3, 0};

  logic        clk;
  logic        rst_n [NDUT];
  logic        en    [NDUT];
  logic        rw    [NDUT];
  logic [1:0]  sz    [NDUT];
  logic        sg    [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] din   [NDUT];
  logic [31:0] dout  [NDUT];
  logic        stall [NDUT];
  logic        done  [NDUT];
  logic        err   [NDUT];

  logic [7:0]  mdl   [NDUT][512];
  logic [31:0] mdout [NDUT];
  exp_t        sbq   [NDUT][$];
  exp_t        mon_e;

  int n_cmp;
  int n_bad;

  data_memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(1)) u_dut0 (
    .Clk(clk), .Reset(rst_n[0]), .MEM_ENABLE(en[0]), .MEM_READWRITE(rw[0]),
    .MEM_SIZE(sz[0]), .MEM_SIGNE(sg[0]), .Address(addr[0]), .DataIn(din[0]),
    .DataOut(dout[0]), .Stall(stall[0]), .Done(done[0]), .Error(err[0]));

  data_memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(3)) u_dut1 (
    .Clk(clk), .Reset(rst_n[1]), .MEM_ENABLE(en[1]), .MEM_READWRITE(rw[1]),
    .MEM_SIZE(sz[1]), .MEM_SIGNE(sg[1]), .Address(addr[1]), .DataIn(din[1]),
    .DataOut(dout[1]), .Stall(stall[1]), .Done(done[1]), .Error(err[1]));

  data_memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) u_dut2 (
    .Clk(clk), .Reset(rst_n[2]), .MEM_ENABLE(en[2]), .MEM_READWRITE(rw[2]),
    .MEM_SIZE(sz[2]), .MEM_SIGNE(sg[2]), .Address(addr[2]), .DataIn(din[2]),
    .DataOut(dout[2]), .Stall(stall[2]), .Done(done[2]), .Error(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, act, expv);
    end
  endtask

  // Reference model: big-endian byte array, access size in bytes, alignment
  // by modulo, sign extension by subtracting 2^(8n) from negative values.
  task automatic model_push(int d, bit w, logic [1:0] s, bit sgn,
                            logic [31:0] a, logic [31:0] wd);
    int     n;
    int     base;
    longint v;
    exp_t   e;
    n    = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    base = int'(a % 512);
    if (base % n != 0) begin
      mdout[d] = '0;
      e.err    = 1'b1;
    end else if (w) begin
      for (int i = 0; i < n; i++)
        mdl[d][base + i] = 8'(wd >> (8 * (n - 1 - i)));
      e.err = 1'b0;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | longint'(mdl[d][base + i]);
      if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      mdout[d] = 32'(v);
      e.err    = 1'b0;
    end
    e.dout = mdout[d];
    sbq[d].push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete access; entered and left at posedge+1. Stall and Done are
  // checked every cycle against the expected WAIT_CYCLES+2 latency, and the
  // request inputs are scrambled after capture.
  task automatic do_access(int d, bit w, logic [1:0] s, bit sgn,
                           logic [31:0] a, logic [31:0] wd);
    int lat;
    lat = wc[d] + 2;
    model_push(d, w, s, sgn, a, wd);
    en[d] = 1'b1; rw[d] = w; sz[d] = s; sg[d] = sgn; addr[d] = a; din[d] = wd;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("stall", d, {31'b0, stall[d]}, {31'b0, k < lat});
      check("done_latency", d, {31'b0, done[d]}, {31'b0, k == lat});
      @(posedge clk);
      #1;
      if (k < lat) begin
        addr[d] = $urandom;
        din[d]  = $urandom;
        rw[d]   = 1'($urandom_range(0, 1));
        sz[d]   = 2'($urandom_range(0, 3));
        sg[d]   = 1'($urandom_range(0, 1));
      end
    end
    en[d] = 1'b0;
  endtask

  task automatic rand_access(int d);
    bit          w;
    bit          sgn;
    logic [1:0]  s;
    logic [31:0] a;
    int          n;
    w   = 1'($urandom_range(0, 1));
    sgn = 1'($urandom_range(0, 1));
    s   = 2'($urandom_range(0, 3));
    n   = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    a   = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) a = a - (a % n);
    do_access(d, w, s, sgn, a, $urandom);
    idle($urandom_range(0, 2));
  endtask

  task automatic fill(int d);
    for (int i = 0; i < 16; i++) do_access(d, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);
  endtask

  // Monitor: pop the next prediction whenever an instance reports Done.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (done[i] === 1'b1) begin
        if (sbq[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done dut%0d: got Done=1 expected no response", i);
        end else begin
          mon_e = sbq[i].pop_front();
          check("dataout", i, dout[i], mon_e.dout);
          check("error", i, {31'b0, err[i]}, {31'b0, mon_e.err});
        end
      end
    end
  end

  initial begin
    logic [15:0] pre_lo;
    n_cmp = 0;
    n_bad = 0;
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d] = 1'b0; en[d] = 1'b0; rw[d] = 1'b0; sz[d] = 2'b00;
      sg[d] = 1'b0; addr[d] = '0; din[d] = '0; mdout[d] = '0;
    end
    idle(3);
    for (int d = 0; d < NDUT; d++) begin
      check("reset_dataout", d, dout[d], 32'h0);
      check("reset_done", d, {31'b0, done[d]}, 32'h0);
      check("reset_error", d, {31'b0, err[d]}, 32'h0);
      check("reset_stall", d, {31'b0, stall[d]}, 32'h0);
      rst_n[d] = 1'b1;
    end
    idle(1);
    for (int d = 0; d < NDUT; d++) fill(d);

    // Word round trip and extension on the single-wait instance.
    do_access(0, 1'b1, 2'b10, 1'b0, 32'h010, 32'h8081_7F01);
    do_access(0, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    check("tp1_word_load", 0, dout[0], 32'h8081_7F01);
    do_access(0, 1'b0, 2'b00, 1'b1, 32'h010, 32'h0);
    check("tp2_sbyte", 0, dout[0], 32'hFFFF_FF80);
    do_access(0, 1'b0, 2'b00, 1'b0, 32'h010, 32'h0);
    check("tp2_ubyte", 0, dout[0], 32'h0000_0080);
    do_access(0, 1'b0, 2'b01, 1'b1, 32'h012, 32'h0);
    check("tp2_shalf", 0, dout[0], 32'h0000_7F01);

    // Big-endian halfword store, then misaligned store must leave it intact.
    pre_lo = {mdl[0][32'h22], mdl[0][32'h23]};
    do_access(0, 1'b1, 2'b01, 1'b0, 32'h020, 32'h1234_BEEF);
    do_access(0, 1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
    check("tp3_half_store", 0, dout[0], {16'hBEEF, pre_lo});
    do_access(0, 1'b1, 2'b10, 1'b0, 32'h022, 32'hDEAD_BEEF);
    check("tp4_misaligned_dataout", 0, dout[0], 32'h0);
    do_access(0, 1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
    check("tp4_mem_unchanged", 0, dout[0], {16'hBEEF, pre_lo});
    do_access(0, 1'b0, 2'b01, 1'b1, 32'h011, 32'h0);
    check("tp4_misaligned_load", 0, dout[0], 32'h0);

    // Reset abort on the three-wait instance, with Error set beforehand.
    do_access(1, 1'b1, 2'b10, 1'b0, 32'h030, 32'hCAFE_F00D);
    do_access(1, 1'b0, 2'b01, 1'b0, 32'h031, 32'h0);
    en[1] = 1'b1; rw[1] = 1'b1; sz[1] = 2'b10; sg[1] = 1'b0;
    addr[1] = 32'h030; din[1] = 32'h1234_5678;
    @(negedge clk);
    check("abort_stall_idle", 1, {31'b0, stall[1]}, 32'h1);
    idle(1);
    @(negedge clk);
    check("abort_stall_wait1", 1, {31'b0, stall[1]}, 32'h1);
    idle(1);
    rst_n[1] = 1'b0;
    #1;
    check("abort_stall", 1, {31'b0, stall[1]}, 32'h0);
    check("abort_done", 1, {31'b0, done[1]}, 32'h0);
    check("abort_error", 1, {31'b0, err[1]}, 32'h0);
    check("abort_dataout", 1, dout[1], 32'h0);
    mdout[1] = '0;
    en[1] = 1'b0;
    idle(1);
    rst_n[1] = 1'b1;
    idle(2);
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h030, 32'h0);
    check("tp5_old_contents", 1, dout[1], 32'hCAFE_F00D);

    // Address wrap on the zero-wait instance.
    do_access(2, 1'b1, 2'b00, 1'b0, 32'h0000_0204, 32'h0000_005A);
    do_access(2, 1'b0, 2'b00, 1'b0, 32'h0000_0004, 32'h0);
    check("tp6_wrap", 2, dout[2], 32'h0000_005A);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 150; i++) rand_access(0);
    for (int i = 0; i < 60; i++) rand_access(1);
    for (int i = 0; i < 100; i++) rand_access(2);

    idle(3);
    for (int d = 0; d < NDUT; d++) check("scoreboard_drain", d, 32'(sbq[d].size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
